// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//
// Measures the period and the high time of a slow clock (clk_in) that is
// asynchronous to the fast system clock. The result is in nanoseconds,
// accumulated in UNIT-ns steps, one step per system clock. It is the
// receive-side partner of the ns-programmed clock generator: it either checks
// that generator's output or recovers an ns value from an unknown clock.
//
// Ports
//   clk        in   1           system clock; all logic runs on its rising edge
//   rst_n      in   1           asynchronous reset, active low
//   enable     in   1           1 = measure; 0 = idle and clear lock
//   clk_in     in   1           clock under test, asynchronous to clk
//   period_ns  out  RESOLUTION  last rising-to-rising period, ns
//   high_ns    out  RESOLUTION  last rising-to-falling high time, ns
//   valid      out  1           one-cycle pulse: period_ns/high_ns just updated
//   timeout    out  1           one-cycle pulse: no rising edge within TIMEOUT_NS
//   locked     out  1           level: at least one valid period since arming,
//                               and no timeout since then
// -----------------------------------------------------------------------------
module clk_period_meter #(
  parameter logic [63:0] CLK_FREQUENCY = 64'd420000000,
  parameter logic [63:0] SECOND        = 64'd1000000000,
  parameter logic [63:0] UNIT          = SECOND / CLK_FREQUENCY,
  parameter int          RESOLUTION    = 64,
  parameter logic [63:0] TIMEOUT_NS    = 64'd1000000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clk_in,
  output logic [RESOLUTION-1:0] period_ns,
  output logic [RESOLUTION-1:0] high_ns,
  output logic                  valid,
  output logic                  timeout,
  output logic                  locked
);

  localparam logic [RESOLUTION-1:0] UNIT_R    = RESOLUTION'(UNIT);
  localparam logic [RESOLUTION-1:0] TIMEOUT_R = RESOLUTION'(TIMEOUT_NS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  // Running time since the last accepted rising edge, plus one step.
  // TIMEOUT_NS is kept below 2^RESOLUTION-UNIT, so this never wraps.
  function automatic logic [RESOLUTION-1:0] add_unit(input logic [RESOLUTION-1:0] v);
    return v + UNIT_R;
  endfunction

  function automatic logic past_timeout(input logic [RESOLUTION-1:0] v);
    return (v > TIMEOUT_R);
  endfunction

  state_t                  state, state_nxt;
  logic [RESOLUTION-1:0]   cnt, cnt_nxt;
  logic [RESOLUTION-1:0]   high_cap, high_cap_nxt;
  logic [RESOLUTION-1:0]   period_nxt, high_nxt;
  logic                    valid_nxt, timeout_nxt, locked_nxt;

  logic                    sync_p0, sync_p1, sync_p2;
  logic                    rise, fall;
  logic [RESOLUTION-1:0]   cnt_inc;
  logic                    over;

  // Stage p0/p1: two-flop synchroniser; p2: previous synchronised value used
  // for edge detection. Both edges see the same three-cycle delay, so the
  // measured intervals carry no bias.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= clk_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise    = sync_p1 & ~sync_p2;
  assign fall    = ~sync_p1 & sync_p2;
  assign cnt_inc = add_unit(cnt);
  assign over    = past_timeout(cnt_inc);

  // Next-state and datapath decisions. enable=0 dominates everything; inside
  // MEASURE a timeout dominates a coincident rise so a too-long period is
  // never reported.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    high_cap_nxt = high_cap;
    period_nxt   = period_ns;
    high_nxt     = high_ns;
    valid_nxt    = 1'b0;
    timeout_nxt  = 1'b0;
    locked_nxt   = locked;

    if (!enable) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      locked_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt   = '0;
          state_nxt = ARM;
        end
        ARM: begin
          // A falling edge here belongs to a period we did not see start.
          if (rise) begin
            cnt_nxt   = '0;
            state_nxt = MEASURE;
          end
        end
        MEASURE: begin
          cnt_nxt = cnt_inc;
          if (over) begin
            timeout_nxt = 1'b1;
            locked_nxt  = 1'b0;
            cnt_nxt     = '0;
            state_nxt   = ARM;
          end else if (rise) begin
            period_nxt = cnt_inc;
            high_nxt   = high_cap;
            valid_nxt  = 1'b1;
            locked_nxt = 1'b1;
            cnt_nxt    = '0;
          end else if (fall) begin
            high_cap_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Registered state, counter and outputs; valid/timeout are single-cycle
  // pulses because their next values default to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      high_cap  <= '0;
      period_ns <= '0;
      high_ns   <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      high_cap  <= high_cap_nxt;
      period_ns <= period_nxt;
      high_ns   <= high_nxt;
      valid     <= valid_nxt;
      timeout   <= timeout_nxt;
      locked    <= locked_nxt;
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_period_meter
//
// Directed bench for clk_period_meter with UNIT=2 ns (default frequency) and a
// short 100 ns timeout. clk_in is produced by a cycle-based pattern generator
// driven 1 ns after each clk rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_clk_period_meter;

  localparam int RES = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           clk_in = 1'b0;
  logic [RES-1:0] period_ns, high_ns;
  logic           valid, timeout, locked;

  clk_period_meter #(
    .RESOLUTION (RES),
    .TIMEOUT_NS (64'd100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .clk_in    (clk_in),
    .period_ns (period_ns),
    .high_ns   (high_ns),
    .valid     (valid),
    .timeout   (timeout),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int nvalid = 0, ntimeout = 0;
  int last_vcyc = 0, prev_vcyc = 0, last_tcyc = 0;
  int last_rise_cyc = -1;

  bit gen_on = 1'b0;
  int gen_hi = 4, gen_lo = 6, ph = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One system clock: sample outputs after the edge, then advance clk_in.
  task automatic tick();
    logic old;
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      nvalid++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
    end
    if (timeout) begin
      ntimeout++;
      last_tcyc = cyc;
    end
    if (gen_on) begin
      old = clk_in;
      clk_in = (ph < gen_hi);
      if (clk_in && !old) last_rise_cyc = cyc;
      ph = (ph + 1 == gen_hi + gen_lo) ? 0 : ph + 1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int target, input int bound, input string tag);
    int n = 0;
    while (nvalid < target && n < bound) begin
      tick();
      n++;
    end
    check(tag, 64'(nvalid >= target), 64'd1);
  endtask

  task automatic wait_timeout(input int target, input int bound, input string tag);
    int n = 0;
    while (ntimeout < target && n < bound) begin
      tick();
      n++;
    end
    check(tag, 64'(ntimeout >= target), 64'd1);
  endtask

  initial begin
    int r, c, e, n0, t0;

    // 1: reset held with clk_in toggling, then released while disabled
    gen_hi = 4; gen_lo = 6; ph = 0; gen_on = 1'b1;
    ticks(5);
    check("rst_period", period_ns, 0);
    check("rst_high", high_ns, 0);
    check("rst_flags", {61'd0, valid, timeout, locked}, 0);
    #2 rst_n = 1'b1;
    ticks(30);
    check("dis_no_valid", nvalid, 0);
    check("dis_no_timeout", ntimeout, 0);
    check("dis_locked", locked, 0);

    // 2: period 10 cycles, high 4 -> 20 ns / 8 ns
    gen_on = 1'b0; clk_in = 1'b0;
    ticks(4);
    enable = 1'b1;
    ticks(3);
    gen_hi = 4; gen_lo = 6; ph = 0; gen_on = 1'b1;
    r = cyc + 1;
    wait_valid(1, 40, "t2_first_valid");
    check("t2_first_cyc", last_vcyc, r + 13);
    check("t2_period", period_ns, 20);
    check("t2_high", high_ns, 8);
    check("t2_locked", locked, 1);
    tick();
    check("t2_valid_pulse", valid, 0);
    wait_valid(3, 40, "t2_more_valid");
    check("t2_spacing", last_vcyc - prev_vcyc, 10);
    check("t2_period2", period_ns, 20);

    // 3: generator loopback ns=10 -> k=5, high=low=6 cycles
    gen_on = 1'b0; clk_in = 1'b0;
    ticks(4);
    gen_hi = 6; gen_lo = 6; ph = 0; gen_on = 1'b1;
    n0 = nvalid;
    wait_valid(n0 + 3, 60, "t3_valid");
    check("t3_spacing", last_vcyc - prev_vcyc, 12);
    check("t3_period", period_ns, 24);
    check("t3_high", high_ns, 12);
    check("t3_locked", locked, 1);

    // 4: one more rise, then clk_in stuck high -> timeout 51 cycles later
    t0 = 0;
    while (last_rise_cyc != cyc && t0 < 30) begin
      tick();
      t0++;
    end
    check("t4_found_rise", 64'(last_rise_cyc == cyc), 1);
    gen_on = 1'b0;
    c = cyc;
    n0 = nvalid;
    wait_valid(n0 + 1, 10, "t4_last_valid");
    check("t4_valid_cyc", last_vcyc, c + 3);
    check("t4_locked_before", locked, 1);
    wait_timeout(1, 80, "t4_timeout_seen");
    check("t4_timeout_cyc", last_tcyc, c + 54);
    check("t4_period_held", period_ns, 24);
    check("t4_high_held", high_ns, 12);
    check("t4_locked_clr", locked, 0);
    tick();
    check("t4_timeout_pulse", timeout, 0);
    ph = gen_hi; gen_on = 1'b1;
    n0 = nvalid;
    wait_valid(n0 + 1, 60, "t4_rearm_valid");
    check("t4_rearm_period", period_ns, 24);
    check("t4_rearm_locked", locked, 1);

    // 5: enable drops mid-measure, then re-enable
    ticks(3);
    enable = 1'b0;
    tick();
    check("t5_locked_clr", locked, 0);
    n0 = nvalid;
    t0 = ntimeout;
    ticks(30);
    check("t5_no_valid", nvalid, n0);
    check("t5_no_timeout", ntimeout, t0);
    gen_on = 1'b0; clk_in = 1'b0;
    ticks(5);
    enable = 1'b1;
    ph = 0; gen_on = 1'b1;
    e = cyc;
    wait_valid(n0 + 1, 40, "t5_reen_valid");
    check("t5_reen_cyc", last_vcyc, e + 16);
    check("t5_reen_period", period_ns, 24);

    // 6: asynchronous reset pulse between clock edges
    ticks(3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_period_clr", period_ns, 0);
    check("t6_high_clr", high_ns, 0);
    check("t6_flags_clr", {61'd0, valid, timeout, locked}, 0);
    #1 rst_n = 1'b1;
    n0 = nvalid;
    wait_valid(n0 + 1, 60, "t6_restart_valid");
    check("t6_period", period_ns, 24);
    check("t6_high", high_ns, 12);
    check("t6_locked", locked, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
